// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_write_arbiter                                         |
// | Description : Two-requester arbiter in front of the write port of a      |
// |               shared FIFO. One requester owns the port at a time. The    |
// |               owner pushes one word per cycle with zero latency. It may  |
// |               push at most MAX_BURST consecutive words while the other   |
// |               requester waits. Ties from IDLE alternate by last owner.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1          single clock, rising edge                   |
// |   reset      in   1          synchronous, active-high                    |
// |   req0/req1  in   1          word valid on data0/data1, held until ack   |
// |   data0/1    in   DATA_WIDTH word offered by each requester              |
// |   full       in   1          full flag of the shared FIFO                |
// |   ack0/ack1  out  1          word accepted this cycle                    |
// |   grant0/1   out  1          requester currently owns the write port     |
// |   push       out  1          FIFO write strobe                           |
// |   fifo_data  out  DATA_WIDTH word written when push is high              |
// +--------------------------------------------------------------------------+
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  full,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] fifo_data
);

  // One extra bit over what MAX_BURST-1 strictly needs keeps the counter
  // width at least 1 even for MAX_BURST == 1.
  localparam int               CNT_W      = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nx;
  logic             last_owner;
  logic             last_owner_nx;
  logic             reenter;
  logic             burst_end;

  // ------------------------------------------------------------------------
  // Outputs: grants decode the registered state; acks are combinational so
  // a word is accepted in the same cycle it is presented.
  // ------------------------------------------------------------------------
  assign grant0 = (state == OWN0);
  assign grant1 = (state == OWN1);
  assign ack0   = grant0 & req0 & ~full;
  assign ack1   = grant1 & req1 & ~full;
  assign push   = ack0 | ack1;

  always_comb begin
    fifo_data = '0;
    if (ack0) begin
      fifo_data = data0;
    end else if (ack1) begin
      fifo_data = data1;
    end
  end

  // The owner's ack is implied whenever it is requesting and full is low,
  // so reaching BURST_LAST on that path means this cycle's word closes it.
  assign burst_end = (burst_cnt == BURST_LAST);

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;  // makes requester 0 win the first tie
    end else begin
      state      <= state_nx;
      burst_cnt  <= burst_cnt_nx;
      last_owner <= last_owner_nx;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_nx      = state;
    reenter       = 1'b0;

    // A full FIFO freezes everything: no transition, and the burst counter
    // is untouched below because push is low.
    if (!full) begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_owner)) begin
            state_nx = OWN0;
          end else if (req1) begin
            state_nx = OWN1;
          end
        end

        OWN0: begin
          if (!req0) begin
            state_nx = req1 ? OWN1 : IDLE;
          end else if (burst_end) begin
            if (req1) begin
              state_nx = OWN1;
            end else begin
              reenter = 1'b1;  // lone requester keeps streaming
            end
          end
        end

        OWN1: begin
          if (!req1) begin
            state_nx = req0 ? OWN0 : IDLE;
          end else if (burst_end) begin
            if (req0) begin
              state_nx = OWN0;
            end else begin
              reenter = 1'b1;
            end
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  // Counter restarts on any change of owner state or on a burst re-entry;
  // otherwise it counts accepted words of the current owner.
  always_comb begin
    burst_cnt_nx = burst_cnt;
    if ((state_nx != state) || reenter) begin
      burst_cnt_nx = '0;
    end else if (push) begin
      burst_cnt_nx = burst_cnt + CNT_ONE;
    end
  end

  // Staying in OWNn already implies last_owner == n, so tracking the target
  // state is the same as updating on every entry.
  always_comb begin
    last_owner_nx = last_owner;
    if (state_nx == OWN0) begin
      last_owner_nx = 1'b0;
    end else if (state_nx == OWN1) begin
      last_owner_nx = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Invariants
  // ------------------------------------------------------------------------
  a_no_push_when_full : assert property (@(posedge clk) !(push && full));
  a_single_ack        : assert property (@(posedge clk) !(ack0 && ack1));

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_write_arbiter                                      |
// | Description : Directed bench for fifo_write_arbiter (MAX_BURST = 4).     |
// |               Stimulus loads per-requester word queues and queues the    |
// |               hand-derived per-cycle grant/push pattern and the expected |
// |               order of pushed words. A negedge monitor pops and compares.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       full;
  logic       ack0;
  logic       ack1;
  logic       grant0;
  logic       grant1;
  logic       push;
  logic [7:0] fifo_data;

  fifo_write_arbiter #(
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .full      (full),
    .ack0      (ack0),
    .ack1      (ack1),
    .grant0    (grant0),
    .grant1    (grant1),
    .push      (push),
    .fifo_data (fifo_data)
  );

  always #5 clk = ~clk;

  // cycle n = the cycle following the n-th rising edge
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int c;
    bit g0;
    bit g1;
    bit p;
  } cyc_exp_t;

  typedef struct {
    bit         src;
    logic [7:0] d;
  } word_exp_t;

  cyc_exp_t  exp_cyc[$];
  word_exp_t exp_words[$];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  bit pend0 = 1'b0;
  bit pend1 = 1'b0;
  bit done  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // ------------------------------------------------------------------------
  // Monitor / scoreboard
  // ------------------------------------------------------------------------
  cyc_exp_t  me;
  word_exp_t mw;
  logic [4:0] obs;
  logic [4:0] want;

  always @(negedge clk) begin
    pend0 = ack0;
    pend1 = ack1;

    if (push) begin
      n_checks++;
      if (exp_words.size() == 0) begin
        n_fail++;
        $display("FAIL word_order cyc=%0d: unexpected push src=%0d data=%02h", cyc, ack1, fifo_data);
      end else begin
        mw = exp_words.pop_front();
        if (mw.src != ack1 || mw.d != fifo_data) begin
          n_fail++;
          $display("FAIL word_order cyc=%0d: got src=%0d data=%02h, want src=%0d data=%02h",
                   cyc, ack1, fifo_data, mw.src, mw.d);
        end
      end
    end

    while (exp_cyc.size() > 0 && exp_cyc[0].c <= cyc) begin
      me   = exp_cyc.pop_front();
      obs  = {grant0, grant1, push, ack0, ack1};
      want = {me.g0, me.g1, me.p, me.p & me.g0, me.p & me.g1};
      n_checks++;
      if (me.c != cyc || obs != want || (!me.p && fifo_data != 8'h00) || (push && full)) begin
        n_fail++;
        $display("FAIL cycle_state cyc=%0d (exp for %0d): got g0g1/push/a0a1=%05b data=%02h full=%0d, want %05b",
                 cyc, me.c, obs, fifo_data, full, want);
      end
    end

    if (done) begin
      n_checks++;
      if (exp_cyc.size() != 0 || exp_words.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d cycle and %0d word expectations left, want 0 and 0",
                 exp_cyc.size(), exp_words.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  task automatic refresh();
    req0  = (q0.size() > 0);
    req1  = (q1.size() > 0);
    data0 = req0 ? q0[0] : 8'h00;
    data1 = req1 ? q1[0] : 8'h00;
  endtask

  // advance one clock; retire words acked in the cycle just ended
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend0 && q0.size() > 0) q0.delete(0);
    if (pend1 && q1.size() > 0) q1.delete(0);
    refresh();
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load(input bit which, input logic [7:0] d);
    if (which) q1.push_back(d);
    else       q0.push_back(d);
    refresh();
  endtask

  task automatic ec(input int c, input bit g0, input bit g1, input bit p);
    cyc_exp_t e;
    e.c  = c;
    e.g0 = g0;
    e.g1 = g1;
    e.p  = p;
    exp_cyc.push_back(e);
  endtask

  task automatic ew(input bit src, input logic [7:0] d);
    word_exp_t w;
    w.src = src;
    w.d   = d;
    exp_words.push_back(w);
  endtask

  // n back-to-back pushes by one owner, words d0, d0+1, ...
  task automatic run(input int c0, input int n, input bit own, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      ec(c0 + i, !own, own, 1'b1);
      ew(own, 8'(d0 + i));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Directed tests
  // ------------------------------------------------------------------------
  int b;

  initial begin
    reset = 1'b1;
    full  = 1'b0;
    refresh();

    // Reset state, one IDLE cycle, then three words from requester 0
    apply_reset();
    b = cyc;
    ec(b, 0, 0, 0);
    load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
    ec(b + 1, 1, 0, 1); ew(0, 8'h11);
    ec(b + 2, 1, 0, 1); ew(0, 8'h22);
    ec(b + 3, 1, 0, 1); ew(0, 8'h33);
    ec(b + 4, 1, 0, 0);
    ec(b + 5, 0, 0, 0);
    wait_to(b + 5);

    // Both requesting after reset: 0 wins the tie, bursts of 4 alternate
    apply_reset();
    b = cyc;
    for (int i = 0; i < 8; i++) begin
      load(0, 8'(8'hA0 + i));
      load(1, 8'(8'hB0 + i));
    end
    ec(b, 0, 0, 0);
    run(b + 1,  4, 0, 8'hA0);
    run(b + 5,  4, 1, 8'hB0);
    run(b + 9,  4, 0, 8'hA4);
    run(b + 13, 4, 1, 8'hB4);  // last burst re-enters OWN1 alone
    ec(b + 17, 0, 1, 0);
    ec(b + 18, 0, 0, 0);
    wait_to(b + 18);

    // Full stall of 3 cycles inside an OWN1 burst does not end it
    b = cyc;
    for (int i = 0; i < 4; i++) load(1, 8'(8'hC0 + i));
    ec(b, 0, 0, 0);
    run(b + 1, 2, 1, 8'hC0);
    wait_to(b + 3);
    full = 1'b1;
    load(0, 8'hD0); load(0, 8'hD1);
    ec(b + 3, 0, 1, 0);
    ec(b + 4, 0, 1, 0);
    ec(b + 5, 0, 1, 0);
    run(b + 6, 2, 1, 8'hC2);
    run(b + 8, 2, 0, 8'hD0);
    ec(b + 10, 1, 0, 0);
    ec(b + 11, 0, 0, 0);
    wait_to(b + 6);
    full = 1'b0;
    wait_to(b + 11);

    // Tie with last_owner 0 goes to 1; req1 drops while req0 waits
    b = cyc;
    load(1, 8'hE0); load(1, 8'hE1);
    load(0, 8'hF0); load(0, 8'hF1);
    ec(b, 0, 0, 0);
    run(b + 1, 2, 1, 8'hE0);
    ec(b + 3, 0, 1, 0);
    run(b + 4, 2, 0, 8'hF0);
    ec(b + 6, 1, 0, 0);
    ec(b + 7, 0, 0, 0);
    wait_to(b + 7);

    // Lone requester streams 10 words across burst boundaries
    b = cyc;
    for (int i = 0; i < 10; i++) load(0, 8'(8'h50 + i));
    ec(b, 0, 0, 0);
    run(b + 1, 10, 0, 8'h50);
    ec(b + 11, 1, 0, 0);
    ec(b + 12, 0, 0, 0);
    wait_to(b + 12);

    // Reset mid-burst in OWN1 with both requesting; 0 wins afterwards
    b = cyc;
    for (int i = 0; i < 4; i++) load(1, 8'(8'h60 + i));
    for (int i = 0; i < 3; i++) load(0, 8'(8'h70 + i));
    ec(b, 0, 0, 0);
    run(b + 1, 2, 1, 8'h60);   // word acked in the reset cycle is delivered
    ec(b + 3, 0, 0, 0);
    run(b + 4, 3, 0, 8'h70);
    ec(b + 7, 1, 0, 0);
    run(b + 8, 2, 1, 8'h62);
    ec(b + 10, 0, 1, 0);
    ec(b + 11, 0, 0, 0);
    wait_to(b + 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_to(b + 11);

    tick();
    done = 1'b1;
  end

endmodule
`default_nettype wire
